// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: frame sequencer in front of the maxpool core.
// Accepts one frame configuration at a time, passes the stream through
// unchanged while counting beats and blocks, then holds the stream off for
// the core's 2-cycle output latency before signalling done.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    frame configuration handshake
//   cfg_is_not_max, cfg_is_max, cfg_is_1x1, cfg_blocks   frame configuration
//   s_valid / s_ready / s_data   upstream stream
//   m_valid / m_ready / m_data   stream to the maxpool core
//   m_user                   {is_1x1, is_max, is_not_max} while a frame runs
//   busy                     frame in progress (RUN or FLUSH)
//   done                     one-cycle pulse on return to IDLE after a frame
//   cfg_err                  one-cycle pulse after an illegal configuration
//
// State table:
//   IDLE  | waiting for a configuration; stream held off
//   RUN   | stream passes through, beats and blocks counted
//   FLUSH | 2 cycles waiting for the core's final max output; stream held off
module maxpool_ctrl #(
    parameter int MEMBERS      = 8,
    parameter int KERNEL_W_MAX = 3,
    parameter int BLOCKS_MAX   = 1024,
    parameter int DATA_W       = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic                              cfg_is_not_max,
    input  logic                              cfg_is_max,
    input  logic                              cfg_is_1x1,
    input  logic [$clog2(BLOCKS_MAX+1)-1:0]   cfg_blocks,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_W-1:0]                 m_data,
    output logic [2:0]                        m_user,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err
);

    localparam int BPB_MAX = KERNEL_W_MAX * MEMBERS;
    localparam int BEAT_W  = (BPB_MAX > 1) ? $clog2(BPB_MAX) : 1;
    localparam int BLK_W   = $clog2(BLOCKS_MAX + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST_1X1 = BEAT_W'(BPB_MAX - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST_3X3 = BEAT_W'(MEMBERS - 1);
    localparam logic [BLK_W-1:0]  BLK_LIMIT     = BLK_W'(BLOCKS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Holds cfg_ready low until the first edge after reset release.
    logic armed;

    logic              is_not_max_q;
    logic              is_max_q;
    logic              is_1x1_q;
    logic [BLK_W-1:0]  blocks_q;

    logic [BEAT_W-1:0] beat_cnt;
    logic [BLK_W-1:0]  blk_cnt;
    logic              flush_tmr;
    logic              done_q;
    logic              err_q;

    logic              cfg_legal;
    logic              cfg_accept;
    logic              cfg_reject;
    logic              beat_hs;
    logic              beat_wrap;
    logic              last_beat;
    logic              flush_end;
    logic [BEAT_W-1:0] beat_last;

    // MAX frames need an even block count because the core alternates
    // MAX_2/MAX_4 per block.
    assign cfg_legal = (cfg_is_max || cfg_is_not_max)
                    && !(cfg_is_max && cfg_is_1x1)
                    && (cfg_blocks != '0)
                    && (cfg_blocks <= BLK_LIMIT)
                    && !(cfg_is_max && cfg_blocks[0]);

    assign beat_last = is_1x1_q ? BEAT_LAST_1X1 : BEAT_LAST_3X3;

    // Payload is a plain wire; m_valid qualifies it.
    assign m_data  = s_data;
    assign done    = done_q;
    assign cfg_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_user     = 3'b000;
        busy       = 1'b0;
        cfg_accept = 1'b0;
        cfg_reject = 1'b0;
        beat_hs    = 1'b0;
        beat_wrap  = 1'b0;
        last_beat  = 1'b0;
        flush_end  = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = armed;
                if (cfg_valid && armed) begin
                    if (cfg_legal) begin
                        cfg_accept = 1'b1;
                        state_nxt  = RUN;
                    end else begin
                        cfg_reject = 1'b1;
                    end
                end
            end
            RUN: begin
                busy      = 1'b1;
                s_ready   = m_ready;
                m_valid   = s_valid;
                m_user    = {is_1x1_q, is_max_q, is_not_max_q};
                beat_hs   = s_valid && m_ready;
                beat_wrap = beat_hs && (beat_cnt == beat_last);
                last_beat = beat_wrap && (blk_cnt == blocks_q - BLK_W'(1));
                if (last_beat) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (flush_tmr == 1'b0) begin
                    flush_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed        <= 1'b0;
            is_not_max_q <= 1'b0;
            is_max_q     <= 1'b0;
            is_1x1_q     <= 1'b0;
            blocks_q     <= '0;
            beat_cnt     <= '0;
            blk_cnt      <= '0;
            flush_tmr    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            armed  <= 1'b1;
            done_q <= flush_end;
            err_q  <= cfg_reject;

            if (cfg_accept) begin
                is_not_max_q <= cfg_is_not_max;
                is_max_q     <= cfg_is_max;
                is_1x1_q     <= cfg_is_1x1;
                blocks_q     <= cfg_blocks;
                beat_cnt     <= '0;
                blk_cnt      <= '0;
            end

            if (beat_hs) begin
                if (beat_wrap) begin
                    beat_cnt <= '0;
                    blk_cnt  <= last_beat ? '0 : blk_cnt + BLK_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end

            // Down-counter: loaded with 1 on the last beat, FLUSH exits at
            // terminal count 0, giving exactly two FLUSH cycles.
            if (last_beat) begin
                flush_tmr <= 1'b1;
            end else if (state == FLUSH && flush_tmr != 1'b0) begin
                flush_tmr <= flush_tmr - 1'b1;
            end
        end
    end

endmodule

// File: doc/maxpool_ctrl.md
MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MEMBERS, 8, beats per block in 3x3 mode.
- KERNEL_W_MAX, 3, beat multiplier for 1x1 mode.
- BLOCKS_MAX, 1024, max blocks per frame.
- DATA_W, 128, flattened stream payload width (UNITS*2*WORD_WIDTH).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- cfg_valid, in, 1, frame config offered.
- cfg_ready, out, 1, config accepted when high with cfg_valid.
- cfg_is_not_max, in, 1, frame emits non-max data.
- cfg_is_max, in, 1, frame emits 2x2 max data.
- cfg_is_1x1, in, 1, frame uses 1x1 kernel.
- cfg_blocks, in, clog2(BLOCKS_MAX+1), blocks in frame, 1..BLOCKS_MAX.
- s_valid, in, 1, upstream beat valid.
- s_ready, out, 1, upstream backpressure.
- s_data, in, DATA_W, upstream payload.
- m_valid, out, 1, beat to maxpool core valid.
- m_ready, in, 1, maxpool core ready.
- m_data, out, DATA_W, payload to core.
- m_user, out, 3, {is_1x1, is_max, is_not_max} to core, bit0 = is_not_max.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle pulse after the last beat of a frame.
- cfg_err, out, 1, one-cycle pulse on an illegal config.

Function
REQ-003 FSM states SHALL be IDLE, RUN, and FLUSH.
REQ-004 In IDLE, cfg_ready SHALL be 1, and s_ready and m_valid SHALL be 0.
REQ-005 A config handshake SHALL be legal only if all of the following hold:
- at least one of is_max / is_not_max is set;
- not (is_max and is_1x1);
- cfg_blocks is nonzero and at most BLOCKS_MAX;
- if is_max, cfg_blocks is even (the core alternates MAX_2/MAX_4 per block).
REQ-006 A legal config SHALL be latched and the FSM SHALL move IDLE->RUN on the next edge.
REQ-007 An illegal config SHALL assert cfg_err for one cycle and leave the FSM in IDLE, with nothing latched.
REQ-008 In RUN, m_valid SHALL equal s_valid, s_ready SHALL equal m_ready, and m_data SHALL equal s_data (combinational, zero latency).
REQ-009 m_user SHALL hold the latched config bits for the whole RUN state, and SHALL be 0 outside RUN.
REQ-010 Beat counter beat_cnt SHALL advance on each m_valid&&m_ready handshake and wrap at beats_per_block-1.
- beats_per_block = KERNEL_W_MAX*MEMBERS if is_1x1, else MEMBERS.
REQ-011 Block counter blk_cnt SHALL increment at each beat_cnt wrap.
REQ-012 The handshake where beat_cnt wraps and blk_cnt==cfg_blocks-1 SHALL be the last beat; the FSM SHALL then move RUN->FLUSH.
REQ-013 FLUSH SHALL last exactly 2 cycles, matching the core's 2-cycle max-output latency.
- s_ready, m_valid = 0 throughout.
- Then done pulses for 1 cycle, concurrent with the return to IDLE.
REQ-014 busy SHALL be 1 in RUN and FLUSH, and 0 in IDLE.
REQ-015 A new cfg SHALL NOT be accepted before IDLE is reached; there is no back-to-back overlap.
REQ-016 Stalls (s_valid=0 or m_ready=0) SHALL hold all counters unchanged, with no timeout.
REQ-017 Counter widths SHALL be clog2(KERNEL_W_MAX*MEMBERS) and clog2(BLOCKS_MAX+1), and no overflow is reachable under legal configs.

Reset
REQ-018 While rst=1, asynchronously and independent of clk:
- FSM goes to IDLE and all counters to 0.
- cfg_ready=0, and s_ready, m_valid, m_user, busy, done, cfg_err are all 0.
REQ-019 cfg_ready SHALL rise on the first clk edge after rst deasserts.
REQ-020 Reset mid-RUN SHALL discard the frame without a done pulse; the core shares rst, so its block alignment restarts.

Verification
REQ-021 Config is_not_max=1, blocks=2, stream of 16 beats with no stalls -> m_user=3'b001, FSM goes to FLUSH after beat 16, done pulses 2 cycles later.
REQ-022 Config is_max=1, is_not_max=1, blocks=4, random m_ready -> exactly 32 handshakes pass, no beat is lost or duplicated, done pulses once.
REQ-023 Config is_1x1=1, is_not_max=1, blocks=1 -> 24 beats accepted; the 25th beat is held off with s_ready=0.
REQ-024 Config is_max=1, blocks=3, and separately is_max=1 with is_1x1=1 -> cfg_err pulses once each, busy stays 0.
REQ-025 rst asserted after 5 beats of an 8-block frame -> all outputs 0 immediately with no clk edge needed, no done pulse; a fresh legal config is accepted afterwards.
REQ-026 cfg_valid held high during RUN -> cfg_ready=0 until IDLE, and the second config is accepted only after done.
